// File: rtl/rr_bus_arbiter.sv
// Round-robin arbiter for a shared mux datapath: registered one-hot grant,
// binary select index, ownership hold with an optional hold-time limit.
module rr_bus_arbiter #(
    parameter int unsigned N        = 8,
    parameter int unsigned MAX_HOLD = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [N-1:0]               req,
    output logic [N-1:0]               gnt,
    output logic [$clog2(N)-1:0]       gnt_idx,
    output logic                       gnt_valid,
    output logic                       preempt
);

    localparam int unsigned IW = $clog2(N);
    // hold_cnt only has to reach MAX_HOLD-1; with the limit disabled it saturates
    localparam int unsigned HW = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
    localparam logic [HW-1:0] HOLD_LAST = HW'((MAX_HOLD > 0) ? (MAX_HOLD - 1) : 0);
    localparam logic [IW-1:0] IDX_LAST  = IW'(N - 1);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    state_t          state;
    state_t          state_nxt;
    logic [IW-1:0]   ptr;
    logic [IW-1:0]   ptr_nxt;
    logic [HW-1:0]   hold_cnt;
    logic [HW-1:0]   hold_nxt;
    logic [IW-1:0]   owner_nxt;
    logic            valid_nxt;
    logic            rotate;
    logic [N-1:0]    gnt_nxt;
    logic            preempt_nxt;

    logic [IW-1:0]   owner_succ;
    logic [IW-1:0]   arb_base;
    logic [IW-1:0]   win_idx;
    logic            win_found;
    logic            owner_req;
    logic            at_limit;

    // Successor of the current owner; becomes the new priority pointer on hand-off
    always_comb begin
        owner_succ = (gnt_idx == IDX_LAST) ? '0 : gnt_idx + IW'(1);
    end

    // Scan base: stored pointer when idle, owner's successor when a hand-off is possible
    always_comb begin
        arb_base  = (state == BUSY) ? owner_succ : ptr;
        owner_req = req[gnt_idx];
        at_limit  = (MAX_HOLD != 0) && (hold_cnt == HOLD_LAST);
    end

    // Round-robin scan: first requester at or after arb_base, wrapping modulo N
    always_comb begin
        int unsigned   cand;
        logic [IW-1:0] cand_idx;
        win_found = 1'b0;
        win_idx   = '0;
        cand      = 0;
        cand_idx  = '0;
        for (int unsigned k = 0; k < N; k++) begin
            cand     = (32'(arb_base) + k) % N;
            cand_idx = IW'(cand);
            if (!win_found && req[cand_idx]) begin
                win_found = 1'b1;
                win_idx   = cand_idx;
            end
        end
    end

    // State register plus pointer, hold counter and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            ptr       <= '0;
            hold_cnt  <= '0;
            gnt       <= '0;
            gnt_idx   <= '0;
            gnt_valid <= 1'b0;
            preempt   <= 1'b0;
        end else begin
            state     <= state_nxt;
            ptr       <= ptr_nxt;
            hold_cnt  <= hold_nxt;
            gnt       <= gnt_nxt;
            gnt_idx   <= owner_nxt;
            gnt_valid <= valid_nxt;
            preempt   <= preempt_nxt;
        end
    end

    // Next-state: grant from idle, hold, release hand-off or hold-limit rotation
    always_comb begin
        state_nxt = state;
        ptr_nxt   = ptr;
        hold_nxt  = hold_cnt;
        owner_nxt = gnt_idx;
        valid_nxt = gnt_valid;
        rotate    = 1'b0;
        case (state)
            IDLE: begin
                hold_nxt = '0;
                if (win_found) begin
                    state_nxt = BUSY;
                    owner_nxt = win_idx;
                    valid_nxt = 1'b1;
                end else begin
                    owner_nxt = '0;
                    valid_nxt = 1'b0;
                end
            end
            BUSY: begin
                if (owner_req && !at_limit) begin
                    if (hold_cnt != '1) begin
                        hold_nxt = hold_cnt + HW'(1);
                    end
                end else begin
                    // Release or forced rotation: owner drops to lowest priority
                    ptr_nxt  = owner_succ;
                    rotate   = owner_req;
                    hold_nxt = '0;
                    if (win_found) begin
                        owner_nxt = win_idx;
                        valid_nxt = 1'b1;
                    end else begin
                        state_nxt = IDLE;
                        owner_nxt = '0;
                        valid_nxt = 1'b0;
                    end
                end
            end
            default: begin
                state_nxt = IDLE;
                owner_nxt = '0;
                valid_nxt = 1'b0;
                hold_nxt  = '0;
            end
        endcase
    end

    // Output decode: one-hot grant from the next owner and the rotation pulse
    always_comb begin
        gnt_nxt     = '0;
        preempt_nxt = rotate;
        if (valid_nxt) begin
            gnt_nxt[owner_nxt] = 1'b1;
        end
    end

    // Grant stays at most one-hot and gnt_valid tracks it exactly
    a_onehot : assert property (@(posedge clk) disable iff (rst) $onehot0(gnt));
    a_valid  : assert property (@(posedge clk) disable iff (rst) gnt_valid == (|gnt));

endmodule

// File: tb/tb_rr_bus_arbiter.sv
// Directed bench for rr_bus_arbiter with a cycle-level reference model.
module tb_rr_bus_arbiter;

    localparam int unsigned N        = 8;
    localparam int unsigned MAX_HOLD = 4;
    localparam int unsigned IW       = $clog2(N);

    logic          clk;
    logic          rst;
    logic [N-1:0]  req;
    logic [N-1:0]  gnt;
    logic [IW-1:0] gnt_idx;
    logic          gnt_valid;
    logic          preempt;

    int checks   = 0;
    int failures = 0;

    // Reference model: owner (-1 when idle), priority start, cycles owned so far
    int m_owner  = -1;
    int m_ptr    = 0;
    int m_tenure = 0;
    bit m_pre    = 1'b0;
    bit chk_en   = 1'b0;

    rr_bus_arbiter #(.N(N), .MAX_HOLD(MAX_HOLD)) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .gnt       (gnt),
        .gnt_idx   (gnt_idx),
        .gnt_valid (gnt_valid),
        .preempt   (preempt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int first_req(input int base, input logic [N-1:0] r);
        for (int k = 0; k < int'(N); k++) begin
            if (r[(base + k) % N]) return (base + k) % N;
        end
        return -1;
    endfunction

    // Model advances on every rising edge from the values the DUT also samples
    always @(posedge clk) begin
        int w;
        if (rst) begin
            m_owner = -1; m_ptr = 0; m_tenure = 0; m_pre = 1'b0;
        end else begin
            m_pre = 1'b0;
            if (m_owner < 0) begin
                w = first_req(m_ptr, req);
                if (w >= 0) begin m_owner = w; m_tenure = 1; end
            end else if (req[m_owner] && (MAX_HOLD == 0 || m_tenure < int'(MAX_HOLD))) begin
                m_tenure++;
            end else begin
                m_pre   = req[m_owner];
                m_ptr   = (m_owner + 1) % N;
                w       = first_req(m_ptr, req);
                m_owner = w;
                m_tenure = (w >= 0) ? 1 : 0;
            end
        end
    end

    // Every-cycle comparison against the model, sampled on the falling edge
    always @(negedge clk) begin
        logic [N-1:0] eg;
        if (chk_en) begin
            eg = '0;
            if (m_owner >= 0) eg[m_owner] = 1'b1;
            check("model_gnt", 32'(gnt), 32'(eg));
            check("model_idx", 32'(gnt_idx), (m_owner >= 0) ? 32'(m_owner) : 32'd0);
            check("model_valid", 32'(gnt_valid), 32'(m_owner >= 0));
            check("model_preempt", 32'(preempt), 32'(m_pre));
        end
    end

    task automatic cyc();
        @(negedge clk);
    endtask

    initial begin
        logic [N-1:0] lit;
        int prev;
        rst = 1'b1;
        req = '1;

        // 1: reset dominates a full request vector, then idle
        cyc();
        chk_en = 1'b1;
        cyc();
        check("rst_gnt", 32'(gnt), 32'h0);
        check("rst_idx", 32'(gnt_idx), 32'h0);
        rst = 1'b0;
        req = '0;
        for (int c = 0; c < 3; c++) begin
            cyc();
            check("idle_gnt", 32'(gnt), 32'h0);
            check("idle_valid", 32'(gnt_valid), 32'h0);
            check("idle_preempt", 32'(preempt), 32'h0);
        end

        // 2: two constant requesters alternate every MAX_HOLD cycles
        req = 8'b0000_0101;
        for (int c = 0; c < 12; c++) begin
            cyc();
            lit = ((c / 4) % 2 == 0) ? 8'h01 : 8'h04;
            check("alt_gnt", 32'(gnt), 32'(lit));
            check("alt_idx", 32'(gnt_idx), ((c / 4) % 2 == 0) ? 32'd0 : 32'd2);
            check("alt_preempt", 32'(preempt), 32'(c == 4 || c == 8));
            check("alt_valid", 32'(gnt_valid), 32'h1);
        end
        req = '0;
        cyc(); cyc();

        // 3: lone requester is re-granted on each limit with no gap
        req = 8'h80;
        for (int c = 0; c < 12; c++) begin
            cyc();
            check("solo_gnt", 32'(gnt), 32'h80);
            check("solo_idx", 32'(gnt_idx), 32'd7);
            check("solo_preempt", 32'(preempt), 32'(c > 0 && c % 4 == 0));
        end
        req = '0;
        cyc(); cyc();

        // 4: each owner releases right after its grant; order walks 0..7,0
        req  = '1;
        prev = -1;
        for (int c = 0; c < 9; c++) begin
            cyc();
            check("walk_idx", 32'(gnt_idx), 32'(c % 8));
            check("walk_valid", 32'(gnt_valid), 32'h1);
            if (prev >= 0) req[prev] = 1'b1;
            req[gnt_idx] = 1'b0;
            prev = int'(gnt_idx);
        end
        req = '0;
        cyc(); cyc();

        // 5: release hands off to the next requester without a bubble
        req = 8'b0010_1000;
        cyc();
        check("hand_gnt0", 32'(gnt), 32'h08);
        check("hand_idx0", 32'(gnt_idx), 32'd3);
        req = 8'b0010_0000;
        cyc();
        check("hand_gnt1", 32'(gnt), 32'h20);
        check("hand_idx1", 32'(gnt_idx), 32'd5);
        check("hand_preempt", 32'(preempt), 32'h0);

        // 6: mid-grant reset clears grant and pointer
        rst = 1'b1;
        cyc();
        check("mid_rst_gnt", 32'(gnt), 32'h0);
        check("mid_rst_valid", 32'(gnt_valid), 32'h0);
        rst = 1'b0;
        req = 8'hFF;
        cyc();
        check("post_rst_gnt", 32'(gnt), 32'h01);
        check("post_rst_idx", 32'(gnt_idx), 32'd0);

        // Mixed traffic: requests held for a few cycles, then changed
        for (int c = 0; c < 300; c++) begin
            if (c % 5 == 0) req = N'($urandom);
            cyc();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
